// File: rtl/mos_decoder_sweep.sv
// ============================================================================
// mos_decoder_sweep : Wishbone-driven opcode sweep with result signature/count
// Revision: 1.0
// ============================================================================
`default_nettype none

module mos_decoder_sweep #(
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0100,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [31:0] SIG_SEED      = 32'h0000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  dec_instr_o,
  input  logic [65:0] dec_result_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int c_SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  logic [c_SW-1:0] r_settle;
  logic [7:0]      r_instr;
  logic [7:0]      r_start_op;
  logic [7:0]      r_end_op;
  logic [31:0]     r_sig;
  logic [8:0]      r_count;
  logic            r_busy;
  logic            r_done;
  logic            r_ack;
  logic [31:0]     r_dat;

  logic [31:0] w_off;
  logic        w_sel;
  logic        w_wr;
  logic [2:0]  w_idx;
  logic [31:0] w_fold;
  logic [31:0] w_sig_next;
  logic        w_nz;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Addresses below BASE_ADDR wrap to large offsets, so one compare bounds both ends.
  assign w_off      = wbs_adr_i - BASE_ADDR;
  assign w_sel      = wbs_stb_i & wbs_cyc_i & ~r_ack & (w_off <= 32'h14) & (wbs_adr_i[1:0] == 2'b00);
  assign w_wr       = w_sel & wbs_we_i;
  assign w_idx      = w_off[4:2];
  assign w_fold     = dec_result_i[31:0] ^ dec_result_i[63:32] ^ {30'b0, dec_result_i[65:64]};
  assign w_sig_next = {r_sig[30:0], r_sig[31]} ^ w_fold;
  assign w_nz       = |dec_result_i;
  assign w_unused   = &{1'b0, wbs_dat_i[31:8]};

  always_comb begin
    w_rdata = 32'h0;
    case (w_idx)
      3'd1:    w_rdata = {24'h0, r_start_op};
      3'd2:    w_rdata = {24'h0, r_end_op};
      3'd3:    w_rdata = {16'h0, r_instr, 6'h0, r_done, r_busy};
      3'd4:    w_rdata = r_sig;
      3'd5:    w_rdata = {23'h0, r_count};
      default: w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= 32'h0;
    end else begin
      r_ack <= w_sel;
      r_dat <= w_sel ? w_rdata : 32'h0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= S_IDLE;
      r_settle   <= '0;
      r_instr    <= 8'h00;
      r_start_op <= 8'h00;
      r_end_op   <= 8'hFF;
      r_sig      <= SIG_SEED;
      r_count    <= 9'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_DRIVE: begin
          if (r_settle == c_SETTLE_LAST) begin
            r_settle <= '0;
            r_state  <= S_SAMPLE;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        S_SAMPLE: begin
          r_sig <= w_sig_next;
          if (w_nz) r_count <= r_count + 9'd1;
          if (r_instr == r_end_op) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_instr <= r_instr + 8'd1;
            r_state <= S_DRIVE;
          end
        end
        default: ;
      endcase

      // Bus writes come last so an abort overrides whatever the sweep did this cycle.
      if (w_wr) begin
        case (w_idx)
          3'd0: begin
            if (wbs_dat_i[1]) begin
              r_state  <= S_IDLE;
              r_settle <= '0;
              r_busy   <= 1'b0;
              r_done   <= 1'b0;
            end else if (wbs_dat_i[0] && !r_busy) begin
              r_state  <= S_DRIVE;
              r_settle <= '0;
              r_instr  <= r_start_op;
              r_sig    <= SIG_SEED;
              r_count  <= 9'd0;
              r_busy   <= 1'b1;
              r_done   <= 1'b0;
            end
          end
          3'd1: if (!r_busy) r_start_op <= wbs_dat_i[7:0];
          3'd2: if (!r_busy) r_end_op   <= wbs_dat_i[7:0];
          default: ;
        endcase
      end
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign dec_instr_o = r_instr;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mos_decoder_sweep.sv
// ============================================================================
// tb_mos_decoder_sweep : scoreboard bench for mos_decoder_sweep
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mos_decoder_sweep;

  localparam logic [31:0] BASE = 32'h3000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic [7:0]  instr;
  logic [65:0] result;
  logic        busy, done;

  assign result = {58'b0, instr};

  mos_decoder_sweep #(.BASE_ADDR(BASE), .SETTLE_CYCLES(1), .SIG_SEED(32'h0)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .dec_instr_o(instr), .dec_result_i(result),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every ack consumes one scoreboard entry; read entries check the data.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (e.rd) chk(e.name, rdat, e.exp);
      end
    end
  end

  function automatic logic [31:0] sig_model(input logic [7:0] first, input int n);
    logic [31:0] s;
    logic [7:0]  op;
    s  = 32'h0;
    op = first;
    for (int i = 0; i < n; i++) begin
      s  = {s[30:0], s[31]} ^ {24'h0, op};
      op = op + 8'd1;
    end
    return s;
  endfunction

  task automatic bus(input logic w, input logic [7:0] off, input logic [31:0] d,
                     input logic [31:0] exp, input string name);
    exp_t e;
    logic got;
    e.rd = !w; e.exp = exp; e.name = name;
    sbq.push_back(e);
    stb = 1'b1; cyc = 1'b1; we = w; adr = BASE + {24'h0, off}; wdat = d;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) begin
      void'(sbq.pop_back());
      chk({name, "_ack_timeout"}, 32'h0, 32'h1);
    end
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
    bus(1'b0, off, 32'h0, exp, name);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    bus(1'b1, off, d, 32'h0, "write");
  endtask

  task automatic no_ack(input logic [31:0] a, input string name);
    logic seen;
    seen = 1'b0;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) seen = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0;
    chk(name, {31'h0, seen}, 32'h0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int          n;
    logic [7:0]  seq[$];
    logic [7:0]  pat;
    logic        ok;
    exp_t        e;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    rd(8'h04, 32'h00, "reset_start_op");
    rd(8'h08, 32'hFF, "reset_end_op");
    rd(8'h10, 32'h0, "reset_sig");
    rd(8'h00, 32'h0, "ctrl_reads_zero");

    // Single-opcode sweep
    wr(8'h04, 32'h05);
    wr(8'h08, 32'h05);
    wr(8'h00, 32'h1);
    chk("single_busy_after_start", {31'h0, busy}, 32'h1);
    wait_done(n);
    chk("single_cycles", n, 2);
    rd(8'h10, 32'h0000_0005, "single_sig");
    rd(8'h14, 32'd1, "single_count");
    rd(8'h0C, 32'h0000_0502, "single_status");

    // Wrapping sweep FE..01
    wr(8'h04, 32'hFE);
    wr(8'h08, 32'h01);
    wr(8'h00, 32'h1);
    seq.delete();
    seq.push_back(instr);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (instr != seq[seq.size()-1]) seq.push_back(instr);
    end
    chk("wrap_cycles", n, 8);
    ok = (seq.size() == 4) && seq[0] == 8'hFE && seq[1] == 8'hFF && seq[2] == 8'h00 && seq[3] == 8'h01;
    chk("wrap_opcode_order", {31'h0, ok}, 32'h1);
    rd(8'h10, 32'h0000_040D, "wrap_sig");
    rd(8'h14, 32'd3, "wrap_count");

    // Full sweep
    wr(8'h04, 32'h00);
    wr(8'h08, 32'hFF);
    wr(8'h00, 32'h1);
    wait_done(n);
    chk("full_cycles", n, 512);
    rd(8'h14, 32'd255, "full_count");
    rd(8'h10, sig_model(8'h00, 256), "full_sig");
    chk("full_busy_low", {31'h0, busy}, 32'h0);

    // Abort mid-sweep, with ignored start / START_OP writes while busy
    wr(8'h00, 32'h1);
    n = 0;
    while (instr != 8'h08 && n < 100) begin @(posedge clk); #1; n++; end
    wr(8'h00, 32'h1);
    chk("start_while_busy_ignored", {31'h0, (instr >= 8'h08)}, 32'h1);
    wr(8'h04, 32'h40);
    n = 0;
    while (instr != 8'h10 && n < 100) begin @(posedge clk); #1; n++; end
    wr(8'h00, 32'h3);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    rd(8'h0C, 32'h0000_1000, "abort_status");
    rd(8'h04, 32'h00, "start_op_write_while_busy");
    wr(8'h10, 32'hDEAD_BEEF);
    rd(8'h10, sig_model(8'h00, 16), "abort_sig_retained");
    rd(8'h14, 32'd15, "abort_count");

    // Bus decode and held-strobe ack spacing
    no_ack(BASE + 32'h18, "no_ack_past_end");
    no_ack(BASE + 32'h02, "no_ack_misaligned");
    no_ack(BASE - 32'h04, "no_ack_below_base");
    e.rd = 1'b1; e.exp = 32'h0000_1000; e.name = "held_status";
    repeat (4) sbq.push_back(e);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h0C;
    pat = 8'h0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      pat[i] = ack;
    end
    stb = 1'b0; cyc = 1'b0;
    chk("held_ack_pattern", {24'h0, pat}, 32'h55);

    // Reset asserted mid-sweep
    @(posedge clk); #1;
    wr(8'h00, 32'h1);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_instr", {24'h0, instr}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    rd(8'h10, 32'h0, "rst_sig");
    rd(8'h14, 32'h0, "rst_count");
    rd(8'h04, 32'h00, "rst_start_op");
    rd(8'h08, 32'hFF, "rst_end_op");

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sbq.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
